// File: rtl/bit_index_serializer.sv
// Accepts a multi-hot vector via valid/ready and streams out the index of every
// set bit, one registered beat per index, lowest-first or highest-first.
module bit_index_serializer #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MSB_FIRST = 1'b0,
  localparam int unsigned IDX_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_zero
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pending, w_pending_nxt;
  logic [IDX_W-1:0] r_out, w_out_nxt;
  logic             r_last, w_last_nxt;
  logic             r_zero, w_zero_nxt;

  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_src;
  logic [IDX_W-1:0] w_idx;
  logic             w_one;
  logic             w_src_zero;

  function automatic logic [IDX_W-1:0] f_scan(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    if (MSB_FIRST) begin
      for (int unsigned i = 0; i < WIDTH; i++)
        if (v[i]) idx = IDX_W'(i);
    end else begin
      for (int unsigned i = WIDTH; i > 0; i--)
        if (v[i-1]) idx = IDX_W'(i - 1);
    end
    return idx;
  endfunction

  // One scanner serves both the capture beat (scan the input) and every
  // subsequent beat (scan pending with the just-accepted bit removed).
  always_comb begin
    w_rem      = r_pending & ~(WIDTH'(1) << r_out);
    w_src      = (r_state == S_IDLE) ? in : w_rem;
    w_idx      = f_scan(w_src);
    w_src_zero = (w_src == '0);
    w_one      = !w_src_zero && ((w_src & (w_src - WIDTH'(1))) == '0);
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_out_nxt     = r_out;
    w_last_nxt    = r_last;
    w_zero_nxt    = r_zero;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt   = S_EMIT;
          w_pending_nxt = in;
          w_out_nxt     = w_idx;
          w_last_nxt    = w_one | w_src_zero;
          w_zero_nxt    = w_src_zero;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (r_last) begin
            w_state_nxt   = S_IDLE;
            w_pending_nxt = '0;
          end else begin
            w_pending_nxt = w_rem;
            w_out_nxt     = w_idx;
            w_last_nxt    = w_one;
            w_zero_nxt    = 1'b0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_out     <= '0;
      r_last    <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_out     <= w_out_nxt;
      r_last    <= w_last_nxt;
      r_zero    <= w_zero_nxt;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_EMIT);
  assign out       = r_out;
  assign out_last  = out_valid & r_last;
  assign out_zero  = out_valid & r_zero;

endmodule

// File: tb/tb_bit_index_serializer.sv
// Bench for bit_index_serializer: two 32-bit instances (lowest/highest first)
// driven in lockstep, plus an 8-bit instance for the mid-burst reset case.
module tb_bit_index_serializer;

  logic        clk = 1'b0;
  logic        rst_n, rst8_n;
  logic [31:0] din;
  logic        din_v, dout_r;
  logic [7:0]  d8;
  logic        d8_v, r8;

  logic        lo_ready, lo_valid, lo_last, lo_zero;
  logic [4:0]  lo_out;
  logic        hi_ready, hi_valid, hi_last, hi_zero;
  logic [4:0]  hi_out;
  logic        b_ready, b_valid, b_last, b_zero;
  logic [2:0]  b_out;

  int errors = 0;
  int checks = 0;

  int exp_lo[32];
  int exp_hi[32];
  int exp_n;
  bit exp_zero;

  always #5 clk = ~clk;

  bit_index_serializer #(.WIDTH(32), .MSB_FIRST(1'b0)) u_lo (
    .clk(clk), .rst_n(rst_n), .in(din), .in_valid(din_v), .in_ready(lo_ready),
    .out(lo_out), .out_valid(lo_valid), .out_ready(dout_r), .out_last(lo_last), .out_zero(lo_zero));

  bit_index_serializer #(.WIDTH(32), .MSB_FIRST(1'b1)) u_hi (
    .clk(clk), .rst_n(rst_n), .in(din), .in_valid(din_v), .in_ready(hi_ready),
    .out(hi_out), .out_valid(hi_valid), .out_ready(dout_r), .out_last(hi_last), .out_zero(hi_zero));

  bit_index_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b8 (
    .clk(clk), .rst_n(rst8_n), .in(d8), .in_valid(d8_v), .in_ready(b_ready),
    .out(b_out), .out_valid(b_valid), .out_ready(r8), .out_last(b_last), .out_zero(b_zero));

  // Reference: list of set-bit positions in ascending order, reversed for MSB-first.
  task automatic build_model(input logic [31:0] v);
    exp_n = 0;
    for (int i = 0; i < 32; i++)
      if (v[i]) begin
        exp_lo[exp_n] = i;
        exp_n++;
      end
    exp_zero = (exp_n == 0);
    if (exp_zero) begin
      exp_lo[0] = 0;
      exp_n     = 1;
    end
    for (int j = 0; j < exp_n; j++) exp_hi[j] = exp_lo[exp_n-1-j];
  endtask

  // Captures v into both 32-bit instances and walks all beats; entered and
  // left 1 time unit after a rising edge.
  task automatic drive_and_check_vector(input logic [31:0] v, input int stall_beat,
                                        input int stall_cnt, input int rnd_pct);
    int  j, stalled, cyc;
    bit  rdy, e_last;
    build_model(v);
    checks++;
    if ({lo_ready, hi_ready} !== 2'b11) begin
      errors++;
      $display("FAIL pre_capture_ready v=%h: lo=%b hi=%b want 1", v, lo_ready, hi_ready);
    end
    din = v; din_v = 1'b1; dout_r = 1'($urandom_range(1));
    @(posedge clk); #1;
    j = 0; stalled = 0; cyc = 0;
    while (j < exp_n && cyc < 400) begin
      cyc++;
      e_last = (j == exp_n - 1);
      checks++;
      if ({lo_valid, lo_out, lo_last, lo_zero, lo_ready} !==
          {1'b1, 5'(exp_lo[j]), e_last, exp_zero, 1'b0}) begin
        errors++;
        $display("FAIL lo_beat v=%h j=%0d: valid=%b out=%0d last=%b zero=%b ready=%b want 1 %0d %b %b 0",
                 v, j, lo_valid, lo_out, lo_last, lo_zero, lo_ready, exp_lo[j], e_last, exp_zero);
      end
      checks++;
      if ({hi_valid, hi_out, hi_last, hi_zero, hi_ready} !==
          {1'b1, 5'(exp_hi[j]), e_last, exp_zero, 1'b0}) begin
        errors++;
        $display("FAIL hi_beat v=%h j=%0d: valid=%b out=%0d last=%b zero=%b ready=%b want 1 %0d %b %b 0",
                 v, j, hi_valid, hi_out, hi_last, hi_zero, hi_ready, exp_hi[j], e_last, exp_zero);
      end
      rdy = 1'b1;
      if (j == stall_beat && stalled < stall_cnt) begin
        rdy = 1'b0;
        stalled++;
      end else if ($urandom_range(99) < rnd_pct) begin
        rdy = 1'b0;
      end
      dout_r = rdy;
      din_v  = 1'($urandom_range(1));
      din    = $urandom;
      @(posedge clk); #1;
      if (rdy) j++;
    end
    din_v = 1'b0; dout_r = 1'b0;
    checks++;
    if ({lo_valid, lo_ready, hi_valid, hi_ready} !== 4'b0101 || j != exp_n) begin
      errors++;
      $display("FAIL post_vector v=%h: lo v/r=%b%b hi v/r=%b%b beats=%0d want 01 01 %0d",
               v, lo_valid, lo_ready, hi_valid, hi_ready, j, exp_n);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rst8_n = 1'b0;
    din = '1; din_v = 1'b1; dout_r = 1'b0;
    d8 = '1; d8_v = 1'b1; r8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    din_v = 1'b0; d8_v = 1'b0;
    checks++;
    if ({lo_valid, lo_out, lo_last, lo_zero, hi_valid, hi_out, hi_last, hi_zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: lo=%b/%0d/%b/%b hi=%b/%0d/%b/%b want all 0",
               lo_valid, lo_out, lo_last, lo_zero, hi_valid, hi_out, hi_last, hi_zero);
    end
    checks++;
    if ({b_valid, b_out, b_last, b_zero} !== '0 || {lo_ready, hi_ready, b_ready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_b8_ready: b8=%b/%0d/%b/%b ready=%b%b%b want 0/0/0/0 111",
               b_valid, b_out, b_last, b_zero, lo_ready, hi_ready, b_ready);
    end
    rst_n = 1'b1; rst8_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({lo_ready, hi_ready, b_ready, lo_valid, hi_valid, b_valid} !== 6'b111000) begin
      errors++;
      $display("FAIL post_reset_idle: ready=%b%b%b valid=%b%b%b want 111 000",
               lo_ready, hi_ready, b_ready, lo_valid, hi_valid, b_valid);
    end
  endtask

  task automatic test_walk_one;
    logic [31:0] v;
    for (int i = 0; i < 32; i++) begin
      v = 32'h1 << i;
      drive_and_check_vector(v, -1, 0, 0);
    end
  endtask

  task automatic test_burst;
    drive_and_check_vector(32'h8000_0011, -1, 0, 0);
  endtask

  task automatic test_backpressure;
    drive_and_check_vector(32'h8000_0011, 1, 3, 0);
    drive_and_check_vector(32'hA5A5_0F0F, 0, 2, 40);
  endtask

  task automatic test_zero;
    drive_and_check_vector(32'h0, -1, 0, 0);
    drive_and_check_vector(32'h0, 0, 2, 0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(4))
        0: v = $urandom & $urandom & $urandom;
        1: v = $urandom | $urandom;
        2: v = 32'h1 << $urandom_range(31);
        3: v = (n % 7 == 0) ? 32'h0 : $urandom;
        default: v = $urandom;
      endcase
      drive_and_check_vector(v, $urandom_range(3), $urandom_range(2), (n < 30) ? 0 : 30);
    end
  endtask

  task automatic test_reset_mid_burst;
    d8 = 8'hFF; d8_v = 1'b1; r8 = 1'b1;
    @(posedge clk); #1;
    d8_v = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({b_valid, b_out, b_last, b_zero} !== {1'b1, 3'(k), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL b8_beat k=%0d: valid=%b out=%0d last=%b zero=%b want 1 %0d 0 0",
                 k, b_valid, b_out, b_last, b_zero, k);
      end
      if (k < 2) begin
        @(posedge clk); #1;
      end
    end
    rst8_n = 1'b0; r8 = 1'b0;
    @(posedge clk); #1;
    rst8_n = 1'b1;
    checks++;
    if ({b_valid, b_ready, b_out} !== {1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL b8_after_reset: valid=%b ready=%b out=%0d want 0 1 0", b_valid, b_ready, b_out);
    end
    d8 = 8'h80; d8_v = 1'b1;
    @(posedge clk); #1;
    d8_v = 1'b0;
    checks++;
    if ({b_valid, b_out, b_last, b_zero, b_ready} !== {1'b1, 3'd7, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b8_single: valid=%b out=%0d last=%b zero=%b ready=%b want 1 7 1 0 0",
               b_valid, b_out, b_last, b_zero, b_ready);
    end
    r8 = 1'b1;
    @(posedge clk); #1;
    r8 = 1'b0;
    checks++;
    if ({b_valid, b_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b8_done: valid=%b ready=%b want 0 1", b_valid, b_ready);
    end
  endtask

  initial begin
    test_reset();
    test_walk_one();
    test_burst();
    test_backpressure();
    test_zero();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
